ddr_traffic_gen: RTL and testbench
==================================

DDR_TRAFFIC_GEN -- requirements
Module: ddr_traffic_gen

Interface
REQ-001 Parameter AXI_ID, default 8'h00: constant value driven on axi_arid.
REQ-002 acr_clk  in  1  sole clock; all logic rising-edge.
REQ-003 acr_rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; launches a test when idle.
REQ-005 base_addr  in  32  test start address; bits [6:0] ignored (128-B aligned).
REQ-006 num_bursts  in  16  number of 16-beat bursts to write, then read back.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse at test end.
REQ-009 err_cnt  out  16  saturating count of mismatched beats (plus bad responses, see REQ-027).
REQ-010 AXI master ports, directions opposite to the DDR subsystem: out axi_awaddr[31:0], axi_awlen[3:0], axi_awsize[2:0], axi_awburst[1:0], axi_awlock, axi_awcache[3:0], axi_awprot[2:0], axi_awvalid; in axi_awready; out axi_wdata[63:0], axi_wstrb[7:0], axi_wlast, axi_wvalid; in axi_wready; in axi_bid[7:0], axi_bresp[1:0], axi_bvalid; out axi_bready; out axi_arid[7:0], axi_araddr[31:0], axi_arlen[3:0], axi_arsize[2:0], axi_arburst[1:0], axi_arlock, axi_arcache[3:0], axi_arprot[2:0], axi_arvalid; in axi_arready; in axi_rid[7:0], axi_rdata[63:0], axi_rresp[1:0], axi_rlast, axi_rvalid; out axi_rready.

Function
REQ-011 Constant fields: awlen/arlen=4'hF, awsize/arsize=3'd3, awburst/arburst=2'b01 (INCR), lock/cache/prot=0, wstrb=8'hFF, arid=AXI_ID.
REQ-012 FSM states IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, FIN; exactly one outstanding burst at any time.
REQ-013 IDLE: start with num_bursts!=0 -> WR_AW, busy=1; burst index k=0; start with num_bursts==0 -> FIN, no bus activity.
REQ-014 Burst k address = {base_addr[31:7],7'b0} + 128*k, 32-bit wrap-around, no 4-KB crossing possible.
REQ-015 WR_AW: awvalid=1, awaddr stable until awready; handshake -> WR_W.
REQ-016 WR_W: 16 beats, wvalid held until wready; beat j data = {A, ~A}, A = burst addr + 8*j; wlast=1 on j=15 only; last handshake -> WR_B.
REQ-017 WR_B: bready=1; bvalid -> next burst WR_AW, or RD_AR with k=0 after burst num_bursts-1.
REQ-018 RD_AR: arvalid=1, araddr stable until arready -> RD_R.
REQ-019 RD_R: rready=1; each rvalid beat compared to REQ-016 pattern; mismatch increments err_cnt.
REQ-020 rlast on the 16th beat -> next RD_AR or FIN; rlast early/late is not an error source, beat counter governs.
REQ-021 FIN: done=1 for one cycle, busy=0, -> IDLE; err_cnt holds until next accepted start, which clears it to 0.
REQ-022 err_cnt saturates at 16'hFFFF; never wraps.
REQ-023 start while busy is ignored.
REQ-024 valid never deasserts before its handshake; valid never depends combinationally on ready.

Reset
REQ-025 acr_rst at any time, including mid-burst: FSM -> IDLE, all valids/readies, busy, done, err_cnt = 0 next edge; in-flight transaction abandoned.
REQ-026 All outputs not in REQ-011 reset to 0.

Configuration
REQ-027 Macro DDR_TGEN_RESP_CHECK_EN: defined -> bresp!=OKAY, rresp!=OKAY, or rid!=AXI_ID each add one to err_cnt per offending handshake (same cycle as data mismatch counts once); undefined -> responses and IDs ignored.

Structure
REQ-028 Package ddr_tgen_pkg holds: FSM state enum, BURST_BEATS=16, BURST_BYTES=128, AXI resp codes, pattern function (addr -> 64-bit data).
REQ-029 Single module, no sub-module; beat and burst counters inline.

Verification
REQ-030 base=0x1000_0000, num_bursts=1, zero-wait slave memory -> one AW at 0x1000_0000, 16 W beats, beat0 data 0x10000000EFFFFFFF, wlast on beat 15, done, err_cnt=0.
REQ-031 num_bursts=3, random ready stalls -> AW addresses 0x..00/0x..80/0x..100 then same ARs, valids stable under stall, err_cnt=0.
REQ-032 Slave corrupts read beat 5 of burst 0 -> err_cnt=1 at done.
REQ-033 num_bursts=0 -> done one cycle after start, no valid asserted.
REQ-034 acr_rst asserted during WR_W beat 7 -> all outputs 0 next cycle; new start runs clean test.
REQ-035 With DDR_TGEN_RESP_CHECK_EN, bresp=SLVERR once -> err_cnt=1; without macro -> err_cnt=0.

Source files
------------

// File: rtl/ddr_tgen_pkg.sv
// Shared types and helpers for the DDR traffic generator.
// The data pattern is derived from the beat address, so a read can be checked without storing the written data.
package ddr_tgen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_AW,
        S_WR_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_FIN
    } tgen_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int BURST_BEATS = 16;
    localparam int BURST_BYTES = 128;

    function automatic logic [63:0] tgen_pattern(input logic [31:0] addr);
        return {addr, ~addr};
    endfunction

endpackage

// File: rtl/ddr_traffic_gen.sv
// DDR traffic generator: writes num_bursts 16-beat bursts, reads them back and counts bad beats.
// Optional macro DDR_TGEN_RESP_CHECK_EN also counts bad BRESP/RRESP/RID.
module ddr_traffic_gen
    import ddr_tgen_pkg::*;
#(
    parameter logic [7:0] AXI_ID = 8'h00
) (
    input  logic        acr_clk,
    input  logic        acr_rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_bursts,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic [31:0] axi_awaddr,
    output logic [3:0]  axi_awlen,
    output logic [2:0]  axi_awsize,
    output logic [1:0]  axi_awburst,
    output logic        axi_awlock,
    output logic [3:0]  axi_awcache,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [63:0] axi_wdata,
    output logic [7:0]  axi_wstrb,
    output logic        axi_wlast,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [7:0]  axi_bid,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic [7:0]  axi_arid,
    output logic [31:0] axi_araddr,
    output logic [3:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic        axi_arlock,
    output logic [3:0]  axi_arcache,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [7:0]  axi_rid,
    input  logic [63:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    input  logic        axi_rvalid,
    output logic        axi_rready
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_BEATS - 1);

    tgen_state_e state_q, state_d;
    logic [31:7] base_q;
    logic [15:0] nbursts_q;
    logic [15:0] burst_q;
    logic [3:0]  beat_q;
    logic [15:0] err_q;

    logic [31:0] burst_addr;
    logic [31:0] beat_addr;
    logic        last_burst;
    logic        last_beat;
    logic        start_ok;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        r_bad, b_bad, err_inc;
    logic        unused_inputs;

    assign burst_addr = {base_q, 7'b0} + 32'(burst_q) * 32'(BURST_BYTES);
    assign beat_addr  = burst_addr + {25'b0, beat_q, 3'b0};
    assign last_burst = (burst_q == nbursts_q - 16'd1);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign start_ok   = (state_q == S_IDLE) && start;

    assign aw_hs = (state_q == S_WR_AW) && axi_awready;
    assign w_hs  = (state_q == S_WR_W)  && axi_wready;
    assign b_hs  = (state_q == S_WR_B)  && axi_bvalid;
    assign ar_hs = (state_q == S_RD_AR) && axi_arready;
    assign r_hs  = (state_q == S_RD_R)  && axi_rvalid;

`ifdef DDR_TGEN_RESP_CHECK_EN
    assign r_bad = (axi_rdata != tgen_pattern(beat_addr))
                || (axi_rresp != RESP_OKAY)
                || (axi_rid != AXI_ID);
    assign b_bad = (axi_bresp != RESP_OKAY);
`else
    assign r_bad = (axi_rdata != tgen_pattern(beat_addr));
    assign b_bad = 1'b0;
`endif

    // a beat with both a data and a response fault still counts once
    assign err_inc = (r_hs && r_bad) || (b_hs && b_bad);

    assign unused_inputs = ^{axi_bid, axi_rlast, axi_bresp, axi_rresp, axi_rid};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (num_bursts == '0) ? S_FIN : S_WR_AW;
            S_WR_AW: if (axi_awready) state_d = S_WR_W;
            S_WR_W:  if (axi_wready && last_beat) state_d = S_WR_B;
            S_WR_B:  if (axi_bvalid) state_d = last_burst ? S_RD_AR : S_WR_AW;
            S_RD_AR: if (axi_arready) state_d = S_RD_R;
            S_RD_R:  if (axi_rvalid && last_beat) state_d = last_burst ? S_FIN : S_RD_AR;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge acr_clk) begin
        if (acr_rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            nbursts_q <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q    <= base_addr[31:7];
                nbursts_q <= num_bursts;
                burst_q   <= '0;
                beat_q    <= '0;
                err_q     <= '0;
            end else begin
                if (aw_hs || ar_hs) beat_q <= '0;
                else if (w_hs || r_hs) beat_q <= beat_q + 4'd1;
                if (b_hs) burst_q <= last_burst ? '0 : burst_q + 16'd1;
                else if (r_hs && last_beat && !last_burst) burst_q <= burst_q + 16'd1;
                if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            end
        end
    end

    // valids come from the state register only, never from ready
    assign axi_awvalid = (state_q == S_WR_AW);
    assign axi_wvalid  = (state_q == S_WR_W);
    assign axi_bready  = (state_q == S_WR_B);
    assign axi_arvalid = (state_q == S_RD_AR);
    assign axi_rready  = (state_q == S_RD_R);

    assign axi_awaddr = axi_awvalid ? burst_addr : '0;
    assign axi_araddr = axi_arvalid ? burst_addr : '0;
    assign axi_wdata  = axi_wvalid ? tgen_pattern(beat_addr) : '0;
    assign axi_wlast  = axi_wvalid && last_beat;

    assign axi_awlen   = 4'hF;
    assign axi_awsize  = 3'd3;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'h0;
    assign axi_awprot  = 3'h0;
    assign axi_wstrb   = 8'hFF;
    assign axi_arid    = AXI_ID;
    assign axi_arlen   = 4'hF;
    assign axi_arsize  = 3'd3;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'h0;
    assign axi_arprot  = 3'h0;

    assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done    = (state_q == S_FIN);
    assign err_cnt = err_q;

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Bench for ddr_traffic_gen: random-stall AXI slave memory plus a
// set-based model of which read beats and responses must be counted.
`timescale 1ns/1ps
module tb_ddr_traffic_gen;
    import ddr_tgen_pkg::*;

    localparam logic [7:0] ID = 8'h5A;

    logic        acr_clk = 1'b0;
    logic        acr_rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [31:0] axi_awaddr;
    logic [3:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid;
    logic        axi_wready = 1'b0;
    logic [7:0]  axi_bid = 8'h0;
    logic [1:0]  axi_bresp = 2'b0;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready = 1'b0;
    logic [7:0]  axi_rid = 8'h0;
    logic [63:0] axi_rdata = 64'h0;
    logic [1:0]  axi_rresp = 2'b0;
    logic        axi_rlast = 1'b0;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;

    always #5 acr_clk = ~acr_clk;

    ddr_traffic_gen #(.AXI_ID(ID)) dut (
        .acr_clk(acr_clk), .acr_rst(acr_rst), .start(start),
        .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int n_checks = 0;
    int n_errs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // test parameters and fault sets (indices are global read beats / B responses)
    logic [31:0] t_base;
    int          t_nb;
    int          stall_pct;
    logic [63:0] mem [logic [31:0]];
    bit          corrupt [int];
    bit          rbad [int];
    bit          bbad [int];

    // slave state
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          w_beat, r_beat, pend_b;
    logic [31:0] w_base, r_base;
    bit          r_act, b_fired, r_fired;
    bit          aw_pend, w_pend, ar_pend;
    logic [31:0] aw_hold, ar_hold;
    logic [63:0] w_hold;
    logic [63:0] beat0;
    bit          saw_valid;

    function automatic logic [31:0] exp_addr(input int k);
        return {t_base[31:7], 7'b0} + 32'(k) * 32'd128;
    endfunction

    function automatic bit rdy();
        return int'($urandom_range(99)) >= stall_pct;
    endfunction

    function automatic int exp_err();
        int e = 0;
        for (int i = 0; i < 16 * t_nb; i++) begin
`ifdef DDR_TGEN_RESP_CHECK_EN
            if (corrupt.exists(i) || rbad.exists(i)) e++;
`else
            if (corrupt.exists(i)) e++;
`endif
        end
`ifdef DDR_TGEN_RESP_CHECK_EN
        e += bbad.num();
`endif
        return e;
    endfunction

    task automatic slave_step();
        logic [31:0] a;
        logic [63:0] d;
        if (acr_rst) begin
            axi_awready = 0; axi_wready = 0; axi_arready = 0;
            axi_bvalid = 0; axi_rvalid = 0;
            b_fired = 0; r_fired = 0; pend_b = 0; r_act = 0;
            w_beat = 0; r_beat = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
        end else begin
            saw_valid |= axi_awvalid | axi_wvalid | axi_arvalid;
            if (aw_pend) chk("aw_stable", 64'({axi_awvalid, axi_awaddr}), 64'({1'b1, aw_hold}));
            if (w_pend) begin
                chk("w_stable_v", 64'(axi_wvalid), 64'(1));
                chk("w_stable_d", axi_wdata, w_hold);
            end
            if (ar_pend) chk("ar_stable", 64'({axi_arvalid, axi_araddr}), 64'({1'b1, ar_hold}));

            axi_awready = rdy();
            axi_wready  = rdy();
            axi_arready = rdy();

            if (axi_awvalid && axi_awready) begin
                chk("aw_addr", 64'(axi_awaddr), 64'(exp_addr(aw_cnt)));
                chk("aw_attr",
                    64'({axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot}),
                    64'({4'hF, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0}));
                w_base = exp_addr(aw_cnt);
                aw_cnt++;
            end
            aw_pend = axi_awvalid && !axi_awready;
            aw_hold = axi_awaddr;

            if (axi_wvalid && axi_wready) begin
                a = w_base + 32'(8 * w_beat);
                chk("w_data", axi_wdata, {a, ~a});
                chk("w_last", 64'(axi_wlast), 64'(w_beat == 15));
                chk("w_strb", 64'(axi_wstrb), 64'(8'hFF));
                mem[a] = axi_wdata;
                if (w_cnt == 0) beat0 = axi_wdata;
                w_cnt++;
                w_beat++;
                if (w_beat == 16) begin
                    w_beat = 0;
                    pend_b++;
                end
            end
            w_pend = axi_wvalid && !axi_wready;
            w_hold = axi_wdata;

            if (b_fired) begin axi_bvalid = 0; b_fired = 0; end
            if (!axi_bvalid && pend_b > 0 && rdy()) begin
                axi_bvalid = 1;
                axi_bid = ID;
                axi_bresp = bbad.exists(b_cnt) ? RESP_SLVERR : RESP_OKAY;
            end
            if (axi_bvalid && axi_bready) begin
                b_fired = 1;
                pend_b--;
                b_cnt++;
            end

            if (axi_arvalid && axi_arready) begin
                chk("ar_addr", 64'(axi_araddr), 64'(exp_addr(ar_cnt)));
                chk("ar_attr",
                    64'({axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot}),
                    64'({ID, 4'hF, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0}));
                r_base = exp_addr(ar_cnt);
                ar_cnt++;
                r_act = 1;
                r_beat = 0;
            end
            ar_pend = axi_arvalid && !axi_arready;
            ar_hold = axi_araddr;

            if (r_fired) begin axi_rvalid = 0; r_fired = 0; end
            if (!axi_rvalid && r_act && rdy()) begin
                a = r_base + 32'(8 * r_beat);
                d = mem.exists(a) ? mem[a] : 64'h0;
                if (corrupt.exists(r_cnt)) d = d ^ 64'h0000_0100_0000_0001;
                axi_rdata = d;
                axi_rlast = (r_beat == 15);
                axi_rresp = rbad.exists(r_cnt) ? RESP_SLVERR : RESP_OKAY;
                axi_rid = ID;
                axi_rvalid = 1;
            end
            if (axi_rvalid && axi_rready) begin
                r_fired = 1;
                r_cnt++;
                r_beat++;
                if (r_beat == 16) begin
                    r_beat = 0;
                    r_act = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge acr_clk);
        slave_step();
    endtask

    task automatic prep(input logic [31:0] base, input int nb, input int stall);
        mem.delete();
        corrupt.delete();
        rbad.delete();
        bbad.delete();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        w_beat = 0; r_beat = 0; pend_b = 0; r_act = 0;
        t_base = base; t_nb = nb; stall_pct = stall;
        saw_valid = 0; beat0 = 0;
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_ctl"},
            64'({busy, done, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready}),
            64'(0));
        chk({pfx, "_err"}, 64'(err_cnt), 64'(0));
        chk({pfx, "_addr"}, 64'({axi_awaddr, axi_araddr}), 64'(0));
        chk({pfx, "_wdata"}, axi_wdata, 64'(0));
    endtask

    task automatic go(input bit mid);
        int cyc;
        int e;
        base_addr = t_base;
        num_bursts = 16'(t_nb);
        start = 1;
        tick();
        start = 0;
        if (t_nb == 0) begin
            chk("nb0_done", 64'(done), 64'(1));
            chk("nb0_busy", 64'(busy), 64'(0));
        end else begin
            chk("busy_after_start", 64'(busy), 64'(1));
        end
        if (mid) begin
            repeat (4) tick();
            base_addr = $urandom;
            num_bursts = 16'($urandom_range(1, 9));
            start = 1;
            tick();
            start = 0;
        end
        cyc = 0;
        while (!done && cyc < 20000) begin
            tick();
            cyc++;
        end
        e = exp_err();
        chk("done_seen", 64'(done), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("err_cnt", 64'(err_cnt), 64'(e));
        chk("n_aw", 64'(aw_cnt), 64'(t_nb));
        chk("n_w", 64'(w_cnt), 64'(16 * t_nb));
        chk("n_b", 64'(b_cnt), 64'(t_nb));
        chk("n_ar", 64'(ar_cnt), 64'(t_nb));
        chk("n_r", 64'(r_cnt), 64'(16 * t_nb));
        if (t_nb == 0) chk("nb0_no_valid", 64'(saw_valid), 64'(0));
        tick();
        chk("done_pulse", 64'(done), 64'(0));
        chk("err_hold", 64'(err_cnt), 64'(e));
    endtask

    initial begin
        int cyc;
        int nb;
        acr_rst = 1;
        start = 0;
        base_addr = 0;
        num_bursts = 0;
        repeat (3) tick();
        check_idle("reset");
        acr_rst = 0;
        tick();

        prep(32'h1000_0000, 1, 0);
        go(0);
        chk("beat0", beat0, 64'h10000000EFFFFFFF);

        prep(32'h1234_5678, 0, 0);
        go(0);

        prep(32'h4000_0033, 3, 40);
        go(0);

        prep(32'h0800_0000, 2, 25);
        corrupt[5] = 1;
        go(0);

        prep(32'h0C00_0000, 2, 10);
        bbad[0] = 1;
        go(0);

        prep(32'hFFFF_FF80, 3, 30);
        go(1);

        for (int i = 0; i < 10; i++) begin
            nb = int'($urandom_range(1, 4));
            prep($urandom, nb, int'($urandom_range(0, 60)));
            repeat ($urandom_range(0, 2)) corrupt[int'($urandom_range(16 * nb - 1))] = 1;
            repeat ($urandom_range(0, 1)) rbad[int'($urandom_range(16 * nb - 1))] = 1;
            repeat ($urandom_range(0, 1)) bbad[int'($urandom_range(nb - 1))] = 1;
            go(bit'($urandom_range(1)));
        end

        prep(32'h2000_0040, 2, 0);
        base_addr = t_base;
        num_bursts = 16'd2;
        start = 1;
        tick();
        start = 0;
        cyc = 0;
        while (w_cnt < 7 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("rst_reach_beat7", 64'(cyc < 500), 64'(1));
        acr_rst = 1;
        tick();
        check_idle("rst_mid");
        acr_rst = 0;
        tick();

        prep(32'h2000_0040, 2, 20);
        go(0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
